// File: rtl/reg_file_select_pkg.sv
// rtl/reg_file_select_pkg.sv - shared CPU constants: IR field positions, bus width, R0 index
package reg_file_select_pkg;

  localparam int CPU_WIDTH = 32;
  localparam int CPU_NREGS = 16;

  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;
  localparam int C_HI  = 18;

  localparam logic [3:0] REG_R0 = 4'd0;

endpackage

// File: rtl/reg_file_select_encode.sv
// rtl/reg_file_select_encode.sv - IR field select/encode: one-hot enables, index, C constant
module select_encode
  import reg_file_select_pkg::*;
#(
  parameter int WIDTH = CPU_WIDTH,
  parameter int NREGS = CPU_NREGS
) (
  input  logic [31:0]      ir,
  input  logic             gra,
  input  logic             grb,
  input  logic             grc,
  input  logic             rin,
  input  logic             rout,
  input  logic             baout,
  output logic [NREGS-1:0] we,
  output logic [NREGS-1:0] re,
  output logic [3:0]       sel_idx,
  output logic             any_sel,
  output logic [WIDTH-1:0] c_sign_ext
);

  logic unused_ir;
  assign unused_ir = ^ir[31:RA_HI+1];

  assign any_sel = gra | grb | grc;

  // gra wins over grb, which wins over grc
  always_comb begin
    sel_idx = REG_R0;
    if (gra) begin
      sel_idx = ir[RA_HI:RA_LO];
    end else if (grb) begin
      sel_idx = ir[RB_HI:RB_LO];
    end else if (grc) begin
      sel_idx = ir[RC_HI:RC_LO];
    end
  end

  always_comb begin
    we = '0;
    re = '0;
    if (any_sel && rin) begin
      we[sel_idx] = 1'b1;
    end
    if (any_sel && (rout || baout)) begin
      re[sel_idx] = 1'b1;
    end
  end

  assign c_sign_ext = {{(WIDTH-C_HI-1){ir[C_HI]}}, ir[C_HI:0]};

endmodule

// File: rtl/reg_file_select_gen_register.sv
// rtl/reg_file_select_gen_register.sv - one general register with synchronous clear and load enable
module gen_register #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file_select.sv
// rtl/reg_file_select.sv - 16x32 general register bank with IR-driven select and bus read mux
module reg_file_select
  import reg_file_select_pkg::*;
#(
  parameter int WIDTH = CPU_WIDTH,
  parameter int NREGS = CPU_NREGS
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [31:0]      ir,
  input  logic             gra,
  input  logic             grb,
  input  logic             grc,
  input  logic             rin,
  input  logic             rout,
  input  logic             baout,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] reg_out,
  output logic             reg_drive,
  output logic [WIDTH-1:0] c_sign_ext,
  output logic [3:0]       sel_idx
);

  logic [NREGS-1:0] we;
  logic [NREGS-1:0] re;
  logic             any_sel;
  logic [WIDTH-1:0] q [NREGS];

  select_encode #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_select_encode (
    .ir         (ir),
    .gra        (gra),
    .grb        (grb),
    .grc        (grc),
    .rin        (rin),
    .rout       (rout),
    .baout      (baout),
    .we         (we),
    .re         (re),
    .sel_idx    (sel_idx),
    .any_sel    (any_sel),
    .c_sign_ext (c_sign_ext)
  );

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    gen_register #(
      .WIDTH (WIDTH)
    ) u_reg (
      .clk (clk),
      .clr (clr),
      .en  (we[i]),
      .d   (bus_in),
      .q   (q[i])
    );
  end

  // R0 acts as a zero base address when read through baout
  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (re[i] && !((i == int'(REG_R0)) && baout)) begin
        reg_out = reg_out | q[i];
      end
    end
  end

  assign reg_drive = any_sel & (rout | baout);

endmodule
